// File: rtl/vx_gpr_pkg.sv
// vx_gpr_pkg: shared definitions for the warp register file.
//   - Default configuration constants and the widths derived from them
//     (WIDW, RIDW, RAM_SIZE) for the default build.
//   - gpr_state_e: lifecycle of the file (zero sweep, then normal run).
//   - gpr_addr(): flat storage address {wid, reg}.
package vx_gpr_pkg;

    localparam int GPR_NUM_WARPS   = 4;
    localparam int GPR_NUM_REGS    = 32;
    localparam int GPR_NUM_THREADS = 4;
    localparam int GPR_DATAW       = 32;
    localparam int GPR_NUM_RPORTS  = 3;
    localparam int GPR_BYPASS      = 1;

    localparam int WIDW     = (GPR_NUM_WARPS > 1) ? $clog2(GPR_NUM_WARPS) : 1;
    localparam int RIDW     = $clog2(GPR_NUM_REGS);
    localparam int RAM_SIZE = GPR_NUM_WARPS * GPR_NUM_REGS;

    typedef enum logic {
        GPR_INIT = 1'b0,
        GPR_RUN  = 1'b1
    } gpr_state_e;

    // Register index occupies the low ridw bits, warp id sits above it.
    // The caller truncates the result to its own address width.
    function automatic int unsigned gpr_addr(input int unsigned wid,
                                             input int unsigned rid,
                                             input int unsigned ridw = RIDW);
        return (wid << ridw) | rid;
    endfunction

endpackage

// File: rtl/vx_gpr_bank.sv
// vx_gpr_bank: one lane of the register file.
//   One write port shared by NUM_RPORTS independent array copies, one copy
//   per read operand. Each copy has a registered read that loads only when
//   rd_en is high, so the output holds as a snapshot while the consumer
//   stalls.
// Ports:
//   clk, reset        clock and synchronous active-high reset (output regs)
//   we, waddr, wdata  write port (applied to every copy)
//   rd_en             load the read registers this cycle
//   raddr             per-port read address, port p at [p*ADDRW +: ADDRW]
//   rd_zero           per-port force-zero (register 0 reads)
//   rdata             per-port registered read data, port p at [p*DATAW +: DATAW]
module vx_gpr_bank
    import vx_gpr_pkg::*;
#(
    parameter int DEPTH      = RAM_SIZE,
    parameter int ADDRW      = $clog2(RAM_SIZE),
    parameter int DATAW      = GPR_DATAW,
    parameter int NUM_RPORTS = GPR_NUM_RPORTS,
    parameter int BYPASS     = GPR_BYPASS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [ADDRW-1:0]            waddr,
    input  logic [DATAW-1:0]            wdata,
    input  logic                        rd_en,
    input  logic [NUM_RPORTS*ADDRW-1:0] raddr,
    input  logic [NUM_RPORTS-1:0]       rd_zero,
    output logic [NUM_RPORTS*DATAW-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_port
            logic [DATAW-1:0] mem [DEPTH];
            logic [ADDRW-1:0] ra;
            logic             hit;
            logic [DATAW-1:0] rdata_reg;

            assign ra  = raddr[gi*ADDRW +: ADDRW];
            // Forward the write landing this very cycle; the array itself
            // still returns the pre-write contents.
            assign hit = (BYPASS != 0) && we && (waddr == ra);

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (rd_en) begin
                    if (rd_zero[gi]) begin
                        rdata_reg <= '0;
                    end else if (hit) begin
                        rdata_reg <= wdata;
                    end else begin
                        rdata_reg <= mem[ra];
                    end
                end
            end

            assign rdata[gi*DATAW +: DATAW] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/vx_gpr_file.sv
// vx_gpr_file: warp register file between issue and execute dispatch.
//   After reset a sweep zero-fills every {wid, reg} entry, then the file
//   accepts commit writebacks and one operand-read request per cycle with a
//   one-cycle registered response under valid/ready backpressure.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   wb_valid/wid/rd/tmask/data      commit writeback; wb_ready high in run
//   req_valid/wid/rs, req_ready     operand read request (NUM_RPORTS indices)
//   rsp_valid/wid/data, rsp_ready   operand response, port-major then lane
//   init_done                       zero sweep finished
module vx_gpr_file
    import vx_gpr_pkg::*;
#(
    parameter int NUM_WARPS   = GPR_NUM_WARPS,
    parameter int NUM_REGS    = GPR_NUM_REGS,
    parameter int NUM_THREADS = GPR_NUM_THREADS,
    parameter int DATAW       = GPR_DATAW,
    parameter int NUM_RPORTS  = GPR_NUM_RPORTS,
    parameter int BYPASS      = GPR_BYPASS,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RID_W      = $clog2(NUM_REGS),
    localparam int DEPTH      = NUM_WARPS * NUM_REGS,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wb_valid,
    input  logic [WID_W-1:0]                     wb_wid,
    input  logic [RID_W-1:0]                     wb_rd,
    input  logic [NUM_THREADS-1:0]               wb_tmask,
    input  logic [NUM_THREADS*DATAW-1:0]         wb_data,
    output logic                                 wb_ready,
    input  logic                                 req_valid,
    input  logic [WID_W-1:0]                     req_wid,
    input  logic [NUM_RPORTS*RID_W-1:0]          req_rs,
    output logic                                 req_ready,
    output logic                                 rsp_valid,
    output logic [WID_W-1:0]                     rsp_wid,
    output logic [NUM_RPORTS*NUM_THREADS*DATAW-1:0] rsp_data,
    input  logic                                 rsp_ready,
    output logic                                 init_done
);

    gpr_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                run;
    logic                rsp_valid_reg;
    logic [WID_W-1:0]    rsp_wid_reg;

    logic                req_fire;
    logic                wb_fire;
    logic [ADDR_W-1:0]   wb_addr;
    logic [NUM_RPORTS*ADDR_W-1:0] rd_addr;
    logic [NUM_RPORTS-1:0]        rd_zero;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= GPR_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: one sweep entry per cycle, leave after the last one.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            GPR_INIT: begin
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = GPR_RUN;
                end
            end
            GPR_RUN:  state_next = GPR_RUN;
            default:  state_next = GPR_INIT;
        endcase
    end

    // State outputs
    always_comb begin
        run = 1'b0;
        case (state_reg)
            GPR_RUN: run = 1'b1;
            default: run = 1'b0;
        endcase
    end

    assign init_done = run;
    assign wb_ready  = run;
    assign req_ready = run && (!rsp_valid_reg || rsp_ready);
    assign req_fire  = req_valid && req_ready;
    // Writes to register 0 never reach the arrays.
    assign wb_fire   = wb_valid && run && (wb_rd != '0);
    assign wb_addr   = ADDR_W'(gpr_addr(32'(wb_wid), 32'(wb_rd), RID_W));

    genvar gi, gp;
    generate
        for (gi = 0; gi < NUM_RPORTS; gi++) begin : g_rs
            logic [RID_W-1:0] rs;
            assign rs = req_rs[gi*RID_W +: RID_W];
            assign rd_addr[gi*ADDR_W +: ADDR_W] =
                ADDR_W'(gpr_addr(32'(req_wid), 32'(rs), RID_W));
            assign rd_zero[gi] = (rs == '0);
        end

        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
            logic                        lane_we;
            logic [ADDR_W-1:0]           lane_waddr;
            logic [DATAW-1:0]            lane_wdata;
            logic [NUM_RPORTS*DATAW-1:0] lane_rdata;

            // During the sweep the write port is borrowed to clear entry cnt.
            assign lane_we    = !run || (wb_fire && wb_tmask[gi]);
            assign lane_waddr = run ? wb_addr : cnt_reg;
            assign lane_wdata = run ? wb_data[gi*DATAW +: DATAW] : '0;

            vx_gpr_bank #(
                .DEPTH      (DEPTH),
                .ADDRW      (ADDR_W),
                .DATAW      (DATAW),
                .NUM_RPORTS (NUM_RPORTS),
                .BYPASS     (BYPASS)
            ) u_bank (
                .clk     (clk),
                .reset   (reset),
                .we      (lane_we),
                .waddr   (lane_waddr),
                .wdata   (lane_wdata),
                .rd_en   (req_fire),
                .raddr   (rd_addr),
                .rd_zero (rd_zero),
                .rdata   (lane_rdata)
            );

            for (gp = 0; gp < NUM_RPORTS; gp++) begin : g_map
                assign rsp_data[(gp*NUM_THREADS + gi)*DATAW +: DATAW] =
                    lane_rdata[gp*DATAW +: DATAW];
            end
        end
    endgenerate

    // Response handshake; data registers live in the banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_wid_reg   <= '0;
        end else if (req_fire) begin
            rsp_valid_reg <= 1'b1;
            rsp_wid_reg   <= req_wid;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_wid   = rsp_wid_reg;

endmodule

// File: tb/tb_vx_gpr_file.sv
// tb_vx_gpr_file: randomized and directed stimulus against a register-file
// reference model; expected responses queue up at accept time and a monitor
// compares them when the DUT presents a response.
module tb_vx_gpr_file;

    localparam int NW    = 4;
    localparam int NRG   = 32;
    localparam int NT    = 4;
    localparam int DW    = 32;
    localparam int NP    = 3;
    localparam int BYP   = 1;
    localparam int WW    = 2;
    localparam int RW    = 5;
    localparam int RAMSZ = NW * NRG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 wb_valid;
    logic [WW-1:0]        wb_wid;
    logic [RW-1:0]        wb_rd;
    logic [NT-1:0]        wb_tmask;
    logic [NT*DW-1:0]     wb_data;
    logic                 wb_ready;
    logic                 req_valid;
    logic [WW-1:0]        req_wid;
    logic [NP*RW-1:0]     req_rs;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [WW-1:0]        rsp_wid;
    logic [NP*NT*DW-1:0]  rsp_data;
    logic                 rsp_ready;
    logic                 init_done;

    vx_gpr_file #(
        .NUM_WARPS(NW), .NUM_REGS(NRG), .NUM_THREADS(NT),
        .DATAW(DW), .NUM_RPORTS(NP), .BYPASS(BYP)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
        .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_ready(wb_ready),
        .req_valid(req_valid), .req_wid(req_wid), .req_rs(req_rs),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .init_done(init_done)
    );

    typedef struct {
        logic [WW-1:0]       wid;
        logic [NP*NT*DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: architectural register contents plus
    // handshake status as seen by the consumer.
    logic [DW-1:0] ref_mem [NW][NRG][NT];
    bit m_known     = 1'b0;
    bit m_run       = 1'b0;
    bit m_rsp_valid = 1'b0;
    int m_sweep     = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        bit            exp_rr, acc, wbf;
        exp_t          e;
        logic [RW-1:0] rs;
        logic [DW-1:0] val;
        exp_rr = m_run && (!m_rsp_valid || rsp_ready);
        if (m_known) begin
            chk("req_ready", 512'(req_ready), 512'(exp_rr));
            chk("wb_ready",  512'(wb_ready),  512'(m_run));
            chk("init_done", 512'(init_done), 512'(m_run));
            chk("rsp_valid", 512'(rsp_valid), 512'(m_rsp_valid));
        end
        acc = !reset && req_valid && exp_rr;
        wbf = !reset && wb_valid && m_run;
        if (acc) begin
            e.wid  = req_wid;
            e.data = '0;
            for (int p = 0; p < NP; p++) begin
                rs = req_rs[p*RW +: RW];
                if (rs != 0) begin
                    for (int i = 0; i < NT; i++) begin
                        val = ref_mem[req_wid][rs][i];
                        if (BYP != 0 && wbf && wb_wid == req_wid && wb_rd == rs && wb_tmask[i])
                            val = wb_data[i*DW +: DW];
                        e.data[(p*NT + i)*DW +: DW] = val;
                    end
                end
            end
            sb_q.push_back(e);
        end
        if (wbf && wb_rd != 0) begin
            for (int i = 0; i < NT; i++)
                if (wb_tmask[i]) ref_mem[wb_wid][wb_rd][i] = wb_data[i*DW +: DW];
        end
        if (reset) begin
            m_known     = 1'b1;
            m_run       = 1'b0;
            m_sweep     = 0;
            m_rsp_valid = 1'b0;
            sb_q.delete();
            for (int w = 0; w < NW; w++)
                for (int r = 0; r < NRG; r++)
                    for (int i = 0; i < NT; i++)
                        ref_mem[w][r][i] = '0;
        end else begin
            if (acc) m_rsp_valid = 1'b1;
            else if (rsp_ready) m_rsp_valid = 1'b0;
            if (!m_run) begin
                m_sweep++;
                if (m_sweep == RAMSZ) m_run = 1'b1;
            end
        end
    endtask

    // Inputs change at posedge+1, the model samples at posedge+3.
    task automatic tick();
        #2;
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int wid, input int rd, input logic [NT-1:0] mask,
                          input logic [DW-1:0] base, input logic [DW-1:0] inc);
        wb_valid = 1'b1;
        wb_wid   = WW'(wid);
        wb_rd    = RW'(rd);
        wb_tmask = mask;
        for (int i = 0; i < NT; i++) wb_data[i*DW +: DW] = base + inc * DW'(i);
    endtask

    task automatic set_req(input int wid, input int rs0, input int rs1, input int rs2);
        req_valid = 1'b1;
        req_wid   = WW'(wid);
        req_rs    = {RW'(rs2), RW'(rs1), RW'(rs0)};
    endtask

    task automatic idle();
        wb_valid  = 1'b0;
        wb_wid    = '0;
        wb_rd     = '0;
        wb_tmask  = '0;
        wb_data   = '0;
        req_valid = 1'b0;
        req_wid   = '0;
        req_rs    = '0;
        rsp_ready = 1'b1;
    endtask

    // Monitor: compare the presented response with the oldest expectation;
    // while stalled the same expectation is compared every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=valid required=no_response");
                end else begin
                    chk("rsp_wid",  512'(rsp_wid),  512'(sb_q[0].wid));
                    chk("rsp_data", 512'(rsp_data), 512'(sb_q[0].data));
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Sweep with a request held the whole time; first response is zero.
        set_req(1, 5, 0, 5);
        repeat (RAMSZ + 3) tick();
        idle();
        tick();

        // Write then read back, with register 0 on the middle port.
        set_wb(1, 5, 4'b1111, 32'hA5A5_0001, 32'd1);
        tick();
        idle();
        set_req(1, 5, 0, 5);
        tick();
        idle();
        tick();
        tick();

        // Same-cycle write and read of one register with a partial mask.
        set_wb(2, 7, 4'b1111, 32'h1111_1111, 32'd0);
        tick();
        idle();
        set_wb(2, 7, 4'b0101, 32'hDEAD_BEEF, 32'd0);
        set_req(2, 7, 7, 0);
        tick();
        idle();
        set_req(2, 7, 0, 0);
        tick();
        idle();
        tick();

        // Register 0 ignores writes and reads zero, with or without a
        // concurrent write to it.
        set_wb(0, 0, 4'b1111, 32'hFFFF_FFFF, 32'd0);
        tick();
        idle();
        set_req(0, 0, 0, 0);
        tick();
        set_wb(0, 0, 4'b1111, 32'hFFFF_FFFF, 32'd0);
        set_req(0, 0, 0, 0);
        tick();
        idle();
        tick();

        // Stall: the held response is a snapshot despite later writes.
        set_wb(3, 9, 4'b1111, 32'h0000_1000, 32'd1);
        tick();
        idle();
        set_req(3, 9, 9, 0);
        tick();
        rsp_ready = 1'b0;
        set_req(3, 9, 0, 9);
        set_wb(3, 9, 4'b1111, 32'h2000_0000, 32'd1);
        repeat (3) tick();
        wb_valid  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        idle();
        tick();
        tick();

        // Reset while a response is pending; contents return to zero.
        set_wb(1, 5, 4'b1111, 32'h0000_0055, 32'd1);
        tick();
        idle();
        set_req(1, 5, 0, 0);
        rsp_ready = 1'b0;
        tick();
        idle();
        rsp_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        set_req(1, 5, 5, 9);
        repeat (RAMSZ + 3) tick();
        set_req(3, 9, 7, 5);
        tick();
        idle();
        tick();

        // Random traffic on a narrow address set to provoke collisions.
        repeat (2000) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_wid   = WW'($urandom_range(0, 1));
            r        = $urandom_range(0, 4);
            wb_rd    = (r == 4) ? RW'(31) : RW'(r);
            wb_tmask = NT'($urandom());
            wb_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_valid = 1'($urandom_range(0, 1));
            req_wid   = WW'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) begin
                r = $urandom_range(0, 4);
                req_rs[p*RW +: RW] = (r == 4) ? RW'(31) : RW'(r);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle();
        repeat (4) tick();
        chk("sb_empty", 512'(sb_q.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_gpr_file.md
Name: vx_gpr_file

Overview:
Parametrised warp register file for the issue stage. It generalises the fixed three-port GPR stage in three ways: a configurable read-port count, a registered one-cycle read with valid/ready backpressure, and write-to-read bypass. A reset-time sweep FSM zero-fills every entry. It sits between the decode/ibuffer issue logic and the execute dispatch, and it is fed by the commit writeback.

Parameters:
NUM_WARPS, 4, warps sharing the file; must be a power of 2.
NUM_REGS, 32, registers per warp; must be a power of 2.
NUM_THREADS, 4, lanes per warp, one independent bank per lane.
DATAW, 32, register width.
NUM_RPORTS, 3, read operands per request (2 for integer-only, 3 with FPU).
BYPASS, 1, 1 = same-cycle writeback forwards into a read; 0 = read returns old contents.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  writeback valid
wb_wid  in  WIDW  writeback warp id; WIDW = max(1, clog2(NUM_WARPS))
wb_rd  in  RIDW  destination register; RIDW = clog2(NUM_REGS)
wb_tmask  in  NUM_THREADS  per-lane write enable
wb_data  in  NUM_THREADS*DATAW  per-lane write data
wb_ready  out  1  writeback accepted
req_valid  in  1  read request valid
req_wid  in  WIDW  read warp id
req_rs  in  NUM_RPORTS*RIDW  source register indices; port p is at [p*RIDW +: RIDW]
req_ready  out  1  read request accepted
rsp_valid  out  1  operand response valid
rsp_wid  out  WIDW  warp id echoed from the request
rsp_data  out  NUM_RPORTS*NUM_THREADS*DATAW  operand data, port-major then lane
rsp_ready  in  1  consumer ready
init_done  out  1  high once the zero sweep has finished

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_wid=0, rsp_data=0, init_done=0, wb_ready=0, req_ready=0. The FSM enters INIT with sweep counter cnt=0.
- Storage: NUM_THREADS*NUM_RPORTS arrays, each NUM_WARPS*NUM_REGS deep and DATAW wide. Address is {wid, reg}. All read-port copies of a lane receive the same write.
- FSM INIT:
  - Each cycle, writes 0 to address cnt in every array, then increments cnt.
  - When cnt reaches NUM_WARPS*NUM_REGS-1 and that entry is written, moves to RUN.
  - Sweep length is exactly NUM_WARPS*NUM_REGS cycles (128 at defaults).
  - wb_ready=0 and req_ready=0 throughout INIT.
- FSM RUN:
  - init_done=1 and wb_ready=1.
  - No exit except reset. Reset asserted mid-sweep or mid-run restarts INIT at cnt=0 and drops rsp_valid on the next edge.
- Write:
  - Commits on wb_valid && wb_ready && wb_rd!=0, for lanes where wb_tmask[i]=1.
  - Writes to rd=0 are dropped.
- Read handshake:
  - req_ready = RUN && (!rsp_valid || rsp_ready).
  - A request is accepted on req_valid && req_ready. At the next edge rsp_valid=1, rsp_wid=req_wid and rsp_data is loaded. Latency is 1 cycle.
  - Full throughput of one request per cycle while rsp_ready=1.
  - rsp_valid clears on rsp_ready with no new accept.
- Stall: while rsp_valid && !rsp_ready, rsp_wid and rsp_data are held constant. A later write to a held register does not alter the held data; the response is a snapshot.
- r0: any port with rs=0 returns 0 on all lanes, regardless of bypass.
- Bypass (BYPASS=1):
  - Applies when a write and an accept happen in the same cycle with wb_wid==req_wid, wb_rd==rs_p and rs_p!=0.
  - Lanes with wb_tmask[i]=1 return wb_data[i]. Other lanes return stored data.
  - Applies independently per port, so duplicate rs on several ports all forward.
- BYPASS=0: the same-cycle read returns the pre-write value.
- Write and read to different addresses in the same cycle: no interaction.

Decomposition:
- Shared package vx_gpr_pkg holds:
  - localparams WIDW, RIDW and RAM_SIZE = NUM_WARPS*NUM_REGS;
  - the FSM enum gpr_state_e {GPR_INIT, GPR_RUN};
  - the helper function gpr_addr(wid, reg).
- One sub-module, vx_gpr_bank: a single-lane, 1-write/NUM_RPORTS-read array with the bypass mux and registered read. It is instantiated NUM_THREADS times. The top level owns the FSM, handshake and r0 masking.

Test Plan:
1. Reset, then hold req_valid=1 -> init_done rises after exactly 128 cycles, req_ready stays 0 until then, and the first response has all data 0.
2. Write wid=1, rd=5, tmask=4'b1111, data=32'hA5A5_0001 (per lane +i); next cycle read rs={5,0,5} for wid=1 -> one cycle later rsp_data ports 0 and 2 = A5A5_0001+i, port 1 = 0.
3. Same-cycle write wid=2, rd=7, tmask=4'b0101, data=32'hDEAD_BEEF with a read of wid=2, rs0=7 (prior contents 32'h1111_1111) -> BYPASS=1: lanes 0 and 2 = DEADBEEF, lanes 1 and 3 = 11111111; BYPASS=0: all lanes 11111111.
4. Write rd=0 data=32'hFFFF_FFFF, then read rs=0 -> 0; request with wb_valid=1 rd=0 in the same cycle -> still 0.
5. Accept request A, hold rsp_ready=0 for 3 cycles while writing A's register with a new value -> rsp_data constant at the old value and req_ready=0. Release -> A is consumed, the next request is accepted in the same cycle, and its response shows the new value.
6. Assert reset for 1 cycle mid-stream with rsp_valid=1 -> rsp_valid=0 next cycle, a fresh 128-cycle sweep runs, and previously written registers read 0.
